// File: rtl/fmps_test_pkg.sv
// ----------------------------------------------------------------------------
// fmps_test_pkg
// Shared definitions for the FMPS test packet generator: default header magic,
// header/payload field positions, the stream FSM state type and the payload
// LFSR seed/taps together with its single-step function.
// ----------------------------------------------------------------------------
package fmps_test_pkg;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hB6CF;

  // Header word: {magic[31:16], 0-padded index starting at bit 10, seq[9:0]}
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_INDEX_LSB = 10;
  localparam int HDR_SEQ_W     = 10;

  // Counter payload word: {seq[7:0], index[7:0], word number[15:0]}
  localparam int PAY_SEQ_LSB   = 24;
  localparam int PAY_INDEX_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting towards the MSB
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [15:0] LFSR_SEED_LO = 16'h0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {cur[30:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fmps_test_lfsr.sv
// ----------------------------------------------------------------------------
// fmps_test_lfsr
// 32-bit payload pattern generator. Loads SEED on reset and advances one step
// for every cycle adv is high.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   adv   in   advance one step
//   state out  current LFSR value
// ----------------------------------------------------------------------------
module fmps_test_lfsr
  import fmps_test_pkg::*;
#(
  parameter logic [31:0] SEED = {MAGIC_DEFAULT, LFSR_SEED_LO}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = adv ? lfsr_next(state_q) : state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/fmps_test_packet_gen.sv
// ----------------------------------------------------------------------------
// fmps_test_packet_gen
// Queues one-cycle packet requests and emits each as an AXI-Stream packet:
// one header word followed by NUM_DATA_WORDS payload words.
//   auroraUserClk/auroraReset   clock, synchronous active-high reset
//   auroraChannelUp             link up; gates request acceptance and starts
//   auroraFAstrobe              FA cycle marker: reloads index, bumps seq
//   genPacketStrobe             packet request
//   cfgIndexBase                index loaded on reset and on every FA strobe
//   cfgPacketsPerCycle          accepted requests per FA cycle (0 = no limit)
//   cfgLfsrMode                 payload pattern select (LFSR builds only)
//   FMPS_TEST_AXI_STREAM_TX_*   AXI-Stream master (tdata/tvalid/tlast/tready)
//   droppedCount                saturating count of rejected requests
//   packetCount                 wrapping count of completed packets
// Build option: define FMPS_TEST_LFSR_EN to add the LFSR payload pattern;
// without it the counter pattern is always used and cfgLfsrMode is ignored.
// ----------------------------------------------------------------------------
module fmps_test_packet_gen
  import fmps_test_pkg::*;
#(
  parameter logic [15:0] MAGIC          = MAGIC_DEFAULT,
  parameter int          INDEX_WIDTH    = 5,
  parameter int          NUM_DATA_WORDS = 1,
  parameter int          PENDING_DEPTH  = 8
) (
  input  logic                   auroraUserClk,
  input  logic                   auroraReset,
  input  logic                   auroraChannelUp,
  input  logic                   auroraFAstrobe,
  input  logic                   genPacketStrobe,
  input  logic [INDEX_WIDTH-1:0] cfgIndexBase,
  input  logic [7:0]             cfgPacketsPerCycle,
  input  logic                   cfgLfsrMode,
  output logic [31:0]            FMPS_TEST_AXI_STREAM_TX_tdata,
  output logic                   FMPS_TEST_AXI_STREAM_TX_tvalid,
  output logic                   FMPS_TEST_AXI_STREAM_TX_tlast,
  input  logic                   FMPS_TEST_AXI_STREAM_TX_tready,
  output logic [15:0]            droppedCount,
  output logic [15:0]            packetCount
);

  localparam int                PEND_W    = $clog2(PENDING_DEPTH + 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(PENDING_DEPTH);
  localparam logic [4:0]        LAST_WORD = 5'(NUM_DATA_WORDS - 1);

  state_e                 state_q, state_d;
  logic [PEND_W-1:0]      pending_q, pending_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] pkt_index_q, pkt_index_d;
  logic [HDR_SEQ_W-1:0]   seq_q, seq_d;
  logic [HDR_SEQ_W-1:0]   pkt_seq_q, pkt_seq_d;
  logic [7:0]             accepted_q, accepted_d;
  logic [15:0]            dropped_q, dropped_d;
  logic [15:0]            packets_q, packets_d;
  logic [4:0]             word_q, word_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;

  logic        handshake, limit_hit, accept, start;
  logic [4:0]  next_word;
  logic [31:0] header_word, cnt_word, pay_word;

  assign handshake = tvalid_q && FMPS_TEST_AXI_STREAM_TX_tready;
  assign limit_hit = (cfgPacketsPerCycle != 8'd0) && (accepted_q == cfgPacketsPerCycle);
  assign accept    = genPacketStrobe && auroraChannelUp && (pending_q < PEND_MAX) && !limit_hit;
  // A request accepted while idle starts immediately, so a lone request costs
  // one cycle of latency and never sits in the pending count.
  assign start     = (state_q == ST_IDLE) && auroraChannelUp && ((pending_q != '0) || accept);

  // The word about to be loaded: payload 0 after the header, else the next one.
  assign next_word   = (state_q == ST_HEADER) ? 5'd0 : word_q + 5'd1;
  assign header_word = {MAGIC, 6'(index_q), seq_q};
  assign cnt_word    = {pkt_seq_q[7:0], 8'(pkt_index_q), 11'd0, next_word};

`ifdef FMPS_TEST_LFSR_EN
  logic [31:0] lfsr_state;
  logic        lfsr_adv;

  assign lfsr_adv = handshake && (state_q == ST_DATA);

  fmps_test_lfsr #(
    .SEED({MAGIC, LFSR_SEED_LO})
  ) u_lfsr (
    .clk  (auroraUserClk),
    .rst  (auroraReset),
    .adv  (lfsr_adv),
    .state(lfsr_state)
  );

  // tdata is registered, so a payload handshake must load the value the LFSR
  // takes after this cycle's step.
  always_comb begin
    pay_word = cnt_word;
    if (cfgLfsrMode) pay_word = (state_q == ST_DATA) ? lfsr_next(lfsr_state) : lfsr_state;
  end
`else
  logic unused_lfsr_mode;
  assign unused_lfsr_mode = cfgLfsrMode;
  assign pay_word         = cnt_word;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    word_d      = word_q;
    pkt_index_d = pkt_index_q;
    pkt_seq_d   = pkt_seq_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_HEADER;
          tvalid_d    = 1'b1;
          tlast_d     = 1'b0;
          tdata_d     = header_word;
          pkt_index_d = index_q;
          pkt_seq_d   = seq_q;
        end
      end
      ST_HEADER, ST_DATA: begin
        if (handshake) begin
          if (state_q == ST_DATA && tlast_q) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            state_d = ST_DATA;
            word_d  = next_word;
            tdata_d = pay_word;
            tlast_d = (next_word == LAST_WORD);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (accept && !start)      pending_d = pending_q + PEND_W'(1);
    else if (!accept && start) pending_d = pending_q - PEND_W'(1);

    // The header already took index_q this cycle, so an FA reload overrides
    // the post-start increment and applies from the next packet on.
    index_d = index_q;
    if (auroraFAstrobe) index_d = cfgIndexBase;
    else if (start)     index_d = index_q + INDEX_WIDTH'(1);

    seq_d      = seq_q + HDR_SEQ_W'(auroraFAstrobe);
    accepted_d = (auroraFAstrobe ? 8'd0 : accepted_q) + 8'(accept);

    dropped_d = dropped_q;
    if (genPacketStrobe && !accept && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;

    packets_d = packets_q + 16'((state_q == ST_DATA) && handshake && tlast_q);
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      index_q     <= cfgIndexBase;
      pkt_index_q <= '0;
      seq_q       <= '0;
      pkt_seq_q   <= '0;
      accepted_q  <= '0;
      dropped_q   <= '0;
      packets_q   <= '0;
      word_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      index_q     <= index_d;
      pkt_index_q <= pkt_index_d;
      seq_q       <= seq_d;
      pkt_seq_q   <= pkt_seq_d;
      accepted_q  <= accepted_d;
      dropped_q   <= dropped_d;
      packets_q   <= packets_d;
      word_q      <= word_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign FMPS_TEST_AXI_STREAM_TX_tdata  = tdata_q;
  assign FMPS_TEST_AXI_STREAM_TX_tvalid = tvalid_q;
  assign FMPS_TEST_AXI_STREAM_TX_tlast  = tlast_q;
  assign droppedCount                   = dropped_q;
  assign packetCount                    = packets_q;

endmodule

// File: tb/tb_fmps_test_packet_gen.sv
// ----------------------------------------------------------------------------
// tb_fmps_test_packet_gen
// Directed scenarios plus a randomized run against a transaction-level model:
// each started packet is expanded into a queue of expected beats, popped on
// handshakes, alongside request/drop/limit bookkeeping. Counter payload build.
// ----------------------------------------------------------------------------
module tb_fmps_test_packet_gen;

  localparam int IW = 5;
  localparam int NW = 4;
  localparam int PD = 8;

  logic          clk = 1'b0;
  logic          rst, up, fa, gen, rdy, lfsr_mode;
  logic [IW-1:0] base;
  logic [7:0]    ppc;
  logic [31:0]   dut_tdata;
  logic          dut_tvalid, dut_tlast;
  logic [15:0]   dut_dropped, dut_pkts;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model state
  logic [31:0]   m_q[$];
  int            m_pend;
  logic [IW-1:0] m_idx;
  logic [9:0]    m_seq;
  logic [7:0]    m_acc;
  logic [15:0]   m_drop, m_pkts;

  logic [31:0]   cap[$];   // DUT beats seen on handshakes

  always #5 clk = ~clk;

  fmps_test_packet_gen #(
    .INDEX_WIDTH   (IW),
    .NUM_DATA_WORDS(NW),
    .PENDING_DEPTH (PD)
  ) dut (
    .auroraUserClk                 (clk),
    .auroraReset                   (rst),
    .auroraChannelUp               (up),
    .auroraFAstrobe                (fa),
    .genPacketStrobe               (gen),
    .cfgIndexBase                  (base),
    .cfgPacketsPerCycle            (ppc),
    .cfgLfsrMode                   (lfsr_mode),
    .FMPS_TEST_AXI_STREAM_TX_tdata (dut_tdata),
    .FMPS_TEST_AXI_STREAM_TX_tvalid(dut_tvalid),
    .FMPS_TEST_AXI_STREAM_TX_tlast (dut_tlast),
    .FMPS_TEST_AXI_STREAM_TX_tready(rdy),
    .droppedCount                  (dut_dropped),
    .packetCount                   (dut_pkts)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, got, exp);
    end
  endtask

  // One clock edge of the specification's rules, using the inputs the DUT saw.
  task automatic model_step();
    bit busy, hs, lim, acc_ok, start;
    if (rst) begin
      m_q.delete();
      m_pend = 0;
      m_idx  = base;
      m_seq  = '0;
      m_acc  = '0;
      m_drop = '0;
      m_pkts = '0;
      return;
    end
    busy   = (m_q.size() != 0);
    hs     = busy && rdy;
    lim    = (ppc != 0) && (m_acc == ppc);
    acc_ok = gen && up && (m_pend < PD) && !lim;
    start  = !busy && up && (m_pend > 0 || acc_ok);
    if (gen && !acc_ok && m_drop != 16'hFFFF) m_drop++;
    if (hs) begin
      if (m_q.size() == 1) m_pkts++;
      void'(m_q.pop_front());
    end
    if (start) begin
      m_q.push_back((32'hB6CF << 16) | (32'(m_idx) << 10) | 32'(m_seq));
      for (int k = 0; k < NW; k++)
        m_q.push_back((32'(m_seq % 256) << 24) | (32'(m_idx) << 16) | 32'(k));
    end
    m_pend = m_pend + int'(acc_ok) - int'(start);
    m_acc  = (fa ? 8'd0 : m_acc) + 8'(acc_ok);
    if (start) m_idx = m_idx + 1'b1;
    if (fa) begin
      m_idx = base;
      m_seq = m_seq + 10'd1;
    end
  endtask

  task automatic compare();
    bit          ev;
    logic [31:0] ed;
    ev = (m_q.size() != 0);
    ed = ev ? m_q[0] : 32'h0;
    check("tvalid", 32'(dut_tvalid), 32'(ev));
    check("tlast", 32'(dut_tlast), 32'(ev && m_q.size() == 1));
    check("tdata", dut_tdata, ed);
    check("droppedCount", 32'(dut_dropped), 32'(m_drop));
    check("packetCount", 32'(dut_pkts), 32'(m_pkts));
  endtask

  task automatic tick(input bit st, input bit f);
    gen = st;
    fa  = f;
    if (dut_tvalid === 1'b1 && rdy) cap.push_back(dut_tdata);
    @(posedge clk);
    cycle++;
    model_step();
    #1;
    compare();
    gen = 1'b0;
    fa  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
    cap.delete();
  endtask

  // One request, then idle long enough for a whole packet plus the idle gap.
  task automatic spaced_strobe();
    tick(1, 0);
    repeat (7) tick(0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_idx[4];
    rst = 1'b1; up = 1'b1; fa = 1'b0; gen = 1'b0; rdy = 1'b1;
    lfsr_mode = 1'b0; base = '0; ppc = 8'd0;

    // Reset state and back-to-back spaced packets with index base 0
    do_reset();
    check("reset_tvalid", 32'(dut_tvalid), 32'd0);
    check("reset_tdata", dut_tdata, 32'd0);
    tick(1, 0);
    check("latency_tvalid", 32'(dut_tvalid), 32'd1);
    check("first_header", dut_tdata, 32'hB6CF_0000);
    repeat (7) tick(0, 0);
    for (int p = 1; p < 8; p++) spaced_strobe();
    repeat (4) tick(0, 0);
    check("s1_packets", 32'(dut_pkts), 32'd8);
    check("s1_beats", 32'(cap.size()), 32'd40);
    for (int p = 0; p < 8; p++) check("s1_header", cap[p*5], 32'hB6CF_0000 | (32'(p) << 10));
    check("s1_payload", cap[13], 32'h0002_0002);

    // Stalled sink: first request starts at once, eight queue, tenth is dropped
    do_reset();
    rdy = 1'b0;
    repeat (10) tick(1, 0);
    check("s3_dropped", 32'(dut_dropped), 32'd1);
    check("s3_stalled_header", dut_tdata, 32'hB6CF_0000);
    rdy = 1'b1;
    repeat (70) tick(0, 0);
    check("s3_packets", 32'(dut_pkts), 32'd9);

    // Per-cycle limit of 3 with base 5, then an FA strobe and one more request
    base = 5'd5;
    do_reset();
    ppc = 8'd3;
    repeat (5) spaced_strobe();
    tick(0, 1);
    repeat (2) tick(0, 0);
    spaced_strobe();
    check("s4_dropped", 32'(dut_dropped), 32'd2);
    check("s4_packets", 32'(dut_pkts), 32'd4);
    check("s4_hdr0", cap[0], 32'hB6CF_1400);
    check("s4_hdr1", cap[5], 32'hB6CF_1800);
    check("s4_hdr2", cap[10], 32'hB6CF_1C00);
    check("s4_hdr3", cap[15], 32'hB6CF_1401);

    // Index wrap from base 30
    base = 5'd30;
    ppc  = 8'd0;
    do_reset();
    repeat (4) spaced_strobe();
    exp_idx = '{30, 31, 0, 1};
    for (int p = 0; p < 4; p++) check("s5_index", (cap[p*5] >> 10) & 32'h1F, 32'(exp_idx[p]));

    // Reset in the middle of a payload, then requests with the link down
    base = 5'd0;
    do_reset();
    up = 1'b0;
    tick(1, 0);
    up = 1'b1;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    check("s6_tvalid", 32'(dut_tvalid), 32'd0);
    check("s6_dropped", 32'(dut_dropped), 32'd0);
    check("s6_packets", 32'(dut_pkts), 32'd0);
    up = 1'b0;
    repeat (3) tick(1, 0);
    check("s6_down_dropped", 32'(dut_dropped), 32'd3);
    check("s6_down_tvalid", 32'(dut_tvalid), 32'd0);
    up = 1'b1;

    // Randomized traffic, stalls, FA strobes, link drops and resets
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      up        = ($urandom_range(0, 9) != 0);
      rdy       = $urandom_range(0, 1) != 0;
      lfsr_mode = $urandom_range(0, 1) != 0;
      base      = IW'($urandom);
      if (i % 500 == 0) ppc = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(2, 5));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
